// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the load/store unit: funct3 encodings, MMIO map,
// FSM state type and funct3 legality/alignment helpers.
package riscv_pkg;

   localparam logic [2:0] F3_BYTE   = 3'b000;
   localparam logic [2:0] F3_HALF   = 3'b001;
   localparam logic [2:0] F3_WORD   = 3'b010;
   localparam logic [2:0] F3_DOUBLE = 3'b011;
   localparam logic [2:0] F3_LBU    = 3'b100;
   localparam logic [2:0] F3_LHU    = 3'b101;
   localparam logic [2:0] F3_LWU    = 3'b110;

   localparam logic [31:0] MMIO_LED_ADDR = 32'hF000_0000;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_WAIT,
      LSU_DONE
   } lsu_state_t;

   // Stores only exist for the signed encodings; 64-bit-only forms need RV64.
   function automatic logic f3_legal(input logic [2:0] funct3, input logic we,
                                     input logic is_rv64);
      logic ok;
      case (funct3)
         F3_BYTE, F3_HALF, F3_WORD: ok = 1'b1;
         F3_DOUBLE:                 ok = is_rv64;
         F3_LBU, F3_LHU:            ok = !we;
         F3_LWU:                    ok = !we && is_rv64;
         default:                   ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
      logic bad;
      case (funct3[1:0])
         2'b01:   bad = addr_lo[0];
         2'b10:   bad = |addr_lo[1:0];
         2'b11:   bad = |addr_lo;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side request/response bus of the load/store unit.
interface load_store_unit_if #(
   parameter int XLEN = 32,
   parameter int ALEN = 32
);

   logic                mem_req;
   logic                mem_we;
   logic [ALEN-1:0]     mem_addr;
   logic [XLEN-1:0]     mem_wdata;
   logic [XLEN/8-1:0]   mem_be;
   logic                mem_gnt;
   logic                mem_rvalid;
   logic [XLEN-1:0]     mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and store shift toward memory, load shift and
// sign/zero extension back toward the pipeline.
module lsu_lane_align
   import riscv_pkg::*;
#(
   parameter int  XLEN = 32,
   localparam int NB   = XLEN / 8,
   localparam int OW   = $clog2(NB)
) (
   input  logic [2:0]      funct3_i,
   input  logic [OW-1:0]   offset_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [NB-1:0]   be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o
);

   logic [NB-1:0]   size_mask;
   logic [XLEN-1:0] rshift;

   always_comb begin
      case (funct3_i[1:0])
         2'b00:   size_mask = NB'(8'h01);
         2'b01:   size_mask = NB'(8'h03);
         2'b10:   size_mask = NB'(8'h0F);
         default: size_mask = NB'(8'hFF);
      endcase
      be_o    = size_mask << offset_i;
      wdata_o = wdata_i << {offset_i, 3'b000};
      rshift  = rdata_i >> {offset_i, 3'b000};

      case (funct3_i)
         F3_BYTE: rdata_o = XLEN'($signed(rshift[7:0]));
         F3_HALF: rdata_o = XLEN'($signed(rshift[15:0]));
         F3_WORD: rdata_o = XLEN'($signed(rshift[31:0]));
         F3_LBU:  rdata_o = XLEN'(rshift[7:0]);
         F3_LHU:  rdata_o = XLEN'(rshift[15:0]);
         F3_LWU:  rdata_o = XLEN'(rshift[31:0]);
         default: rdata_o = rshift;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: decodes and checks a pipeline access, runs it on the
// memory bus through a four-state FSM and hosts a small MMIO LED register.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter int              ALEN      = 32,
   parameter int              LED_WIDTH = 4,
   parameter logic [ALEN-1:0] LED_ADDR  = ALEN'(MMIO_LED_ADDR)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [ALEN-1:0]      req_addr,
   input  logic [XLEN-1:0]      req_wdata,
   output logic                 stall,
   output logic                 rsp_valid,
   output logic [XLEN-1:0]      rsp_rdata,
   output logic                 access_err,
   load_store_unit_if.master    mem,
   output logic [LED_WIDTH-1:0] leds_out
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   lsu_state_t           state_q, state_d;
   logic                 we_q;
   logic [2:0]           funct3_q;
   logic [OW-1:0]        offset_q;
   logic [ALEN-1:0]      addr_q;
   logic [XLEN-1:0]      wdata_q;
   logic [NB-1:0]        be_q;
   logic [XLEN-1:0]      rdata_q;
   logic [LED_WIDTH-1:0] leds_q;

   logic                 bad_req;
   logic                 is_mmio;
   logic                 accept;
   logic [2:0]           align_funct3;
   logic [OW-1:0]        align_offset;
   logic [NB-1:0]        align_be;
   logic [XLEN-1:0]      align_wdata;
   logic [XLEN-1:0]      align_rdata;

   assign bad_req = !f3_legal(req_funct3, req_we, XLEN == 64)
                  || f3_misaligned(req_funct3, req_addr[2:0]);
   assign is_mmio = (req_addr == LED_ADDR);
   assign accept  = (state_q == LSU_IDLE) && req_valid && !bad_req;

   // The store path is only needed in IDLE and the load path only in WAIT,
   // so one aligner serves both by switching between live and latched fields.
   assign align_funct3 = (state_q == LSU_IDLE) ? req_funct3 : funct3_q;
   assign align_offset = (state_q == LSU_IDLE) ? req_addr[OW-1:0] : offset_q;

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .funct3_i (align_funct3),
      .offset_i (align_offset),
      .wdata_i  (req_wdata),
      .rdata_i  (mem.mem_rdata),
      .be_o     (align_be),
      .wdata_o  (align_wdata),
      .rdata_o  (align_rdata)
   );

   always_comb begin
      // NOTE: next state defaults to current state first, so no branch leaves it unassigned and no latch is inferred.
      state_d = state_q;
      case (state_q)
         LSU_IDLE: if (accept)          state_d = is_mmio ? LSU_DONE : LSU_REQ;
         LSU_REQ:  if (mem.mem_gnt)     state_d = we_q ? LSU_DONE : LSU_WAIT;
         LSU_WAIT: if (mem.mem_rvalid)  state_d = LSU_DONE;
         LSU_DONE:                      state_d = LSU_IDLE;
         default:                       state_d = LSU_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LSU_IDLE;
         we_q     <= 1'b0;
         funct3_q <= '0;
         offset_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         rdata_q  <= '0;
         leds_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept && !is_mmio) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            offset_q <= req_addr[OW-1:0];
            addr_q   <= {req_addr[ALEN-1:OW], {OW{1'b0}}};
            wdata_q  <= align_wdata;
            be_q     <= align_be;
         end
         if (accept && is_mmio) begin
            if (req_we) leds_q  <= req_wdata[LED_WIDTH-1:0];
            else        rdata_q <= XLEN'(leds_q);
         end
         if ((state_q == LSU_WAIT) && mem.mem_rvalid) rdata_q <= align_rdata;
      end
   end

   // Stall drops in DONE so the pipeline advances in the same cycle as rsp_valid.
   assign stall      = req_valid && (state_q != LSU_DONE) && !bad_req;
   assign access_err = req_valid && (state_q == LSU_IDLE) && bad_req;
   assign rsp_valid  = (state_q == LSU_DONE);
   assign rsp_rdata  = rdata_q;
   assign leds_out   = leds_q;

   assign mem.mem_req   = (state_q == LSU_REQ);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: an RV32 and an RV64 instance share the
// request and memory-response stimulus; only the selected one sees req_valid.
module tb_load_store_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        use64;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [63:0] mem_rdata;

   logic        valid32, valid64;
   logic        stall32, rspv32, err32;
   logic        stall64, rspv64, err64;
   logic [31:0] rdata32;
   logic [63:0] rdata64;
   logic [3:0]  leds32, leds64;

   logic        o_stall, o_rsp_valid, o_err, o_mem_req;
   logic [63:0] o_rdata, o_wdata;
   logic [7:0]  o_be;
   logic [31:0] o_addr;
   logic [3:0]  o_leds;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   load_store_unit_if #(.XLEN(32), .ALEN(32)) if32 ();
   load_store_unit_if #(.XLEN(64), .ALEN(32)) if64 ();

   assign valid32         = req_valid && !use64;
   assign valid64         = req_valid && use64;
   assign if32.mem_gnt    = mem_gnt;
   assign if32.mem_rvalid = mem_rvalid;
   assign if32.mem_rdata  = mem_rdata[31:0];
   assign if64.mem_gnt    = mem_gnt;
   assign if64.mem_rvalid = mem_rvalid;
   assign if64.mem_rdata  = mem_rdata;

   load_store_unit #(.XLEN(32), .ALEN(32), .LED_WIDTH(4)) u32 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (valid32),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata[31:0]),
      .stall      (stall32),
      .rsp_valid  (rspv32),
      .rsp_rdata  (rdata32),
      .access_err (err32),
      .mem        (if32),
      .leds_out   (leds32)
   );

   load_store_unit #(.XLEN(64), .ALEN(32), .LED_WIDTH(4)) u64 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (valid64),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall64),
      .rsp_valid  (rspv64),
      .rsp_rdata  (rdata64),
      .access_err (err64),
      .mem        (if64),
      .leds_out   (leds64)
   );

   always_comb begin
      if (use64) begin
         o_stall = stall64;  o_rsp_valid = rspv64;  o_err = err64;
         o_rdata = rdata64;  o_leds = leds64;
         o_mem_req = if64.mem_req;  o_be = if64.mem_be;
         o_addr = if64.mem_addr;    o_wdata = if64.mem_wdata;
      end else begin
         o_stall = stall32;  o_rsp_valid = rspv32;  o_err = err32;
         o_rdata = {32'h0, rdata32};  o_leds = leds32;
         o_mem_req = if32.mem_req;  o_be = {4'h0, if32.mem_be};
         o_addr = if32.mem_addr;    o_wdata = {32'h0, if32.mem_wdata};
      end
   end

   typedef struct {
      bit          is64;
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;   // memory return for loads
      bit          err;     // expected access_err
      logic [7:0]  be;
      logic [31:0] maddr;
      logic [63:0] mwdata;  // checked for stores only
      logic [63:0] rsp;     // checked for loads only
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [63:0] wdata);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
   endtask

   // Zero-wait transaction: gnt in the first REQ cycle, rvalid the cycle after.
   task automatic run_vec(input vec_t v, input int idx);
      string t;
      t = $sformatf("vec%0d", idx);
      step();
      use64 = v.is64;
      drive_req(v.we, v.f3, v.addr, v.wdata);
      sample();
      check({t, " access_err"}, o_err, v.err);
      check({t, " stall idle"}, o_stall, !v.err);
      check({t, " mem_req idle"}, o_mem_req, 1'b0);
      if (v.err) begin
         step();
         req_valid = 1'b0;
         sample();
         check({t, " mem_req after err"}, o_mem_req, 1'b0);
         check({t, " rsp_valid after err"}, o_rsp_valid, 1'b0);
         return;
      end
      step();
      mem_gnt = 1'b1;
      sample();
      check({t, " mem_req"}, o_mem_req, 1'b1);
      check({t, " mem_be"}, o_be, v.be);
      check({t, " mem_addr"}, o_addr, v.maddr);
      if (v.we) check({t, " mem_wdata"}, o_wdata, v.mwdata);
      step();
      mem_gnt = 1'b0;
      if (!v.we) begin
         mem_rvalid = 1'b1;
         mem_rdata  = v.rdata;
         sample();
         check({t, " rsp_valid in wait"}, o_rsp_valid, 1'b0);
         check({t, " stall in wait"}, o_stall, 1'b1);
         step();
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
      end
      sample();
      check({t, " rsp_valid"}, o_rsp_valid, 1'b1);
      check({t, " stall done"}, o_stall, 1'b0);
      if (!v.we) check({t, " rsp_rdata"}, o_rdata, v.rsp);
      step();
      req_valid = 1'b0;
      sample();
      check({t, " rsp_valid one cycle"}, o_rsp_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      // is64 we f3 addr wdata rdata err be maddr mwdata rsp
      vecs.push_back('{0, 1, 3'b010, 32'h104, 64'hDEADBEEF, 64'h0, 0, 8'h0F, 32'h104, 64'hDEADBEEF, 64'h0});
      vecs.push_back('{0, 1, 3'b000, 32'h103, 64'hA5, 64'h0, 0, 8'h08, 32'h100, 64'hA5000000, 64'h0});
      vecs.push_back('{0, 1, 3'b001, 32'h102, 64'h1234, 64'h0, 0, 8'h0C, 32'h100, 64'h12340000, 64'h0});
      vecs.push_back('{0, 0, 3'b000, 32'h103, 64'h0, 64'h80FFFFFF, 0, 8'h08, 32'h100, 64'h0, 64'hFFFFFF80});
      vecs.push_back('{0, 0, 3'b100, 32'h103, 64'h0, 64'h80FFFFFF, 0, 8'h08, 32'h100, 64'h0, 64'h00000080});
      vecs.push_back('{0, 0, 3'b001, 32'h102, 64'h0, 64'h80011234, 0, 8'h0C, 32'h100, 64'h0, 64'hFFFF8001});
      vecs.push_back('{0, 0, 3'b101, 32'h102, 64'h0, 64'h80011234, 0, 8'h0C, 32'h100, 64'h0, 64'h00008001});
      vecs.push_back('{0, 0, 3'b010, 32'h108, 64'h0, 64'hCAFEF00D, 0, 8'h0F, 32'h108, 64'h0, 64'hCAFEF00D});
      vecs.push_back('{0, 0, 3'b001, 32'h101, 64'h0, 64'h0, 1, 8'h0, 32'h0, 64'h0, 64'h0});
      vecs.push_back('{0, 0, 3'b011, 32'h100, 64'h0, 64'h0, 1, 8'h0, 32'h0, 64'h0, 64'h0});
      vecs.push_back('{0, 0, 3'b110, 32'h100, 64'h0, 64'h0, 1, 8'h0, 32'h0, 64'h0, 64'h0});
      vecs.push_back('{0, 0, 3'b111, 32'h100, 64'h0, 64'h0, 1, 8'h0, 32'h0, 64'h0, 64'h0});
      vecs.push_back('{0, 1, 3'b100, 32'h100, 64'h0, 64'h0, 1, 8'h0, 32'h0, 64'h0, 64'h0});
      vecs.push_back('{0, 1, 3'b010, 32'h102, 64'h0, 64'h0, 1, 8'h0, 32'h0, 64'h0, 64'h0});
      vecs.push_back('{0, 1, 3'b011, 32'h100, 64'h0, 64'h0, 1, 8'h0, 32'h0, 64'h0, 64'h0});
      vecs.push_back('{1, 1, 3'b001, 32'h106, 64'hABCD, 64'h0, 0, 8'hC0, 32'h100, 64'hABCD_0000_0000_0000, 64'h0});
      vecs.push_back('{1, 1, 3'b011, 32'h108, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 8'hFF, 32'h108, 64'h0123_4567_89AB_CDEF, 64'h0});
      vecs.push_back('{1, 1, 3'b010, 32'h104, 64'h1122_3344, 64'h0, 0, 8'hF0, 32'h100, 64'h1122_3344_0000_0000, 64'h0});
      vecs.push_back('{1, 0, 3'b110, 32'h104, 64'h0, 64'h8000_0001_1234_5678, 0, 8'hF0, 32'h100, 64'h0, 64'h0000_0000_8000_0001});
      vecs.push_back('{1, 0, 3'b010, 32'h104, 64'h0, 64'h8000_0001_1234_5678, 0, 8'hF0, 32'h100, 64'h0, 64'hFFFF_FFFF_8000_0001});
      vecs.push_back('{1, 0, 3'b011, 32'h108, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 8'hFF, 32'h108, 64'h0, 64'hFEDC_BA98_7654_3210});
      vecs.push_back('{1, 0, 3'b000, 32'h107, 64'h0, 64'h7F00_0000_0000_0000, 0, 8'h80, 32'h100, 64'h0, 64'h7F});
      vecs.push_back('{1, 0, 3'b011, 32'h104, 64'h0, 64'h0, 1, 8'h0, 32'h0, 64'h0, 64'h0});
      vecs.push_back('{1, 1, 3'b110, 32'h100, 64'h0, 64'h0, 1, 8'h0, 32'h0, 64'h0, 64'h0});

      rst = 1'b1;  use64 = 1'b0;  req_valid = 1'b0;  req_we = 1'b0;
      req_funct3 = '0;  req_addr = '0;  req_wdata = '0;
      mem_gnt = 1'b0;  mem_rvalid = 1'b0;  mem_rdata = '0;
      repeat (2) @(posedge clk);
      sample();
      check("reset stall", o_stall, 1'b0);
      check("reset rsp_valid", o_rsp_valid, 1'b0);
      check("reset mem_req", o_mem_req, 1'b0);
      check("reset rsp_rdata", o_rdata, 64'h0);
      check("reset leds", o_leds, 4'h0);
      step();
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // MMIO store then load of the LED register; no memory traffic either way.
      step();
      use64 = 1'b0;
      drive_req(1'b1, F3_WORD, MMIO_LED_ADDR, 64'h5);
      sample();
      check("mmio st stall", o_stall, 1'b1);
      check("mmio st mem_req", o_mem_req, 1'b0);
      step();
      sample();
      check("mmio st rsp_valid", o_rsp_valid, 1'b1);
      check("mmio st leds", o_leds, 4'h5);
      check("mmio st mem_req done", o_mem_req, 1'b0);
      step();
      req_we = 1'b0;
      sample();
      check("mmio ld not back-to-back", o_rsp_valid, 1'b0);
      check("mmio ld stall", o_stall, 1'b1);
      step();
      sample();
      check("mmio ld rsp_valid", o_rsp_valid, 1'b1);
      check("mmio ld rsp_rdata", o_rdata, 64'h5);
      check("mmio ld mem_req", o_mem_req, 1'b0);
      step();
      req_valid = 1'b0;

      // Reset while waiting for load data; the late rvalid must be dropped.
      drive_req(1'b0, F3_WORD, 32'h100, 64'h0);
      step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      rst = 1'b1;
      req_valid = 1'b0;
      step();
      rst = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 64'hFFFF_FFFF;
      sample();
      check("rst wait stall", o_stall, 1'b0);
      check("rst wait rsp_valid", o_rsp_valid, 1'b0);
      check("rst wait mem_req", o_mem_req, 1'b0);
      check("rst wait leds", o_leds, 4'h0);
      check("rst wait rsp_rdata", o_rdata, 64'h0);
      step();
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      sample();
      check("late rvalid rsp_valid", o_rsp_valid, 1'b0);
      check("late rvalid rsp_rdata", o_rdata, 64'h0);

      // LB with data returning three cycles after the grant.
      step();
      drive_req(1'b0, F3_BYTE, 32'h103, 64'h0);
      sample();
      check("lb slow stall idle", o_stall, 1'b1);
      step();
      mem_gnt = 1'b1;
      sample();
      check("lb slow mem_req", o_mem_req, 1'b1);
      step();
      mem_gnt = 1'b0;
      for (int w = 0; w < 3; w++) begin
         if (w == 2) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 64'h80FF_FFFF;
         end
         sample();
         check($sformatf("lb slow stall wait%0d", w), o_stall, 1'b1);
         check($sformatf("lb slow rsp_valid wait%0d", w), o_rsp_valid, 1'b0);
         check($sformatf("lb slow mem_req wait%0d", w), o_mem_req, 1'b0);
         step();
      end
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      sample();
      check("lb slow rsp_valid", o_rsp_valid, 1'b1);
      check("lb slow rsp_rdata", o_rdata, 64'hFFFF_FF80);
      check("lb slow stall done", o_stall, 1'b0);
      step();
      req_valid = 1'b0;

      // LW with grant held off two cycles and a stray rvalid while in REQ.
      drive_req(1'b0, F3_WORD, 32'h10C, 64'h0);
      step();
      mem_rvalid = 1'b1;
      mem_rdata = 64'h5555_5555;
      for (int r = 0; r < 3; r++) begin
         if (r == 1) mem_rvalid = 1'b0;
         if (r == 2) mem_gnt = 1'b1;
         sample();
         check($sformatf("lw gnt-wait mem_req%0d", r), o_mem_req, 1'b1);
         check($sformatf("lw gnt-wait mem_addr%0d", r), o_addr, 32'h10C);
         check($sformatf("lw gnt-wait mem_be%0d", r), o_be, 8'h0F);
         check($sformatf("lw gnt-wait stall%0d", r), o_stall, 1'b1);
         step();
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 64'h0BAD_F00D;
      sample();
      check("lw gnt-wait rsp_valid wait", o_rsp_valid, 1'b0);
      step();
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      sample();
      check("lw gnt-wait rsp_valid", o_rsp_valid, 1'b1);
      check("lw gnt-wait rsp_rdata", o_rdata, 64'h0BAD_F00D);
      step();
      req_valid = 1'b0;
      sample();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
